// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmit-engine bundle for the shared UART transmit arbiter.
// The master side is the arbiter; the slave side is requesters plus engine.
interface uart_tx_arbiter_if;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  ack;
    logic        tx_rdy;
    logic        tx_write;
    logic [7:0]  tx_data;
    logic        grant_valid;
    logic [1:0]  grant_id;
    logic        busy;
    logic        hold_timeout;

    modport master (
        input  req, req_data, req_last, tx_rdy,
        output ack, tx_write, tx_data,
        output grant_valid, grant_id, busy, hold_timeout
    );

    modport slave (
        output req, req_data, req_last, tx_rdy,
        input  ack, tx_write, tx_data,
        input  grant_valid, grant_id, busy, hold_timeout
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with packet lock sharing one UART transmit engine.
// A grant is held until the owner's last byte or a HOLD_MAX stall.
module uart_tx_arbiter #(
    parameter int NREQ     = 4,
    parameter int HOLD_MAX = 255
) (
    input  logic              clk,
    input  logic              rstsb,
    uart_tx_arbiter_if.master bus
);
    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    localparam logic [7:0] HOLD_END = 8'(HOLD_MAX - 1);

    state_t     state;
    logic [1:0] rr_ptr;
    logic [7:0] hold_cnt;
    logic       last;
    logic [1:0] winner;
    logic [1:0] idx;
    logic       found;
    logic       cur_req;
    logic       cur_last;
    logic [7:0] cur_data;

    // First requester at or after rr_ptr, wrapping modulo 4
    always_comb begin
        winner = rr_ptr;
        found  = 1'b0;
        idx    = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = rr_ptr + 2'(i);
            if (!found && bus.req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    assign cur_req  = bus.req[bus.grant_id];
    assign cur_last = bus.req_last[bus.grant_id];
    assign cur_data = bus.req_data[{bus.grant_id, 3'b000} +: 8];

    always_ff @(posedge clk or negedge rstsb) begin
        if (!rstsb) begin
            state            <= IDLE;
            rr_ptr           <= '0;
            hold_cnt         <= '0;
            last             <= 1'b0;
            bus.ack          <= '0;
            bus.tx_write     <= 1'b0;
            bus.tx_data      <= '0;
            bus.grant_valid  <= 1'b0;
            bus.grant_id     <= '0;
            bus.busy         <= 1'b0;
            bus.hold_timeout <= 1'b0;
        end else begin
            bus.ack          <= '0;
            bus.tx_write     <= 1'b0;
            bus.hold_timeout <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (|bus.req) begin
                        bus.grant_id    <= winner;
                        bus.grant_valid <= 1'b1;
                        bus.busy        <= 1'b1;
                        hold_cnt        <= '0;
                        state           <= SEND;
                    end
                end
                SEND: begin
                    if (bus.tx_rdy) begin
                        if (cur_req) begin
                            bus.tx_write <= 1'b1;
                            bus.tx_data  <= cur_data;
                            bus.ack      <= 4'b0001 << bus.grant_id;
                            last         <= cur_last;
                            hold_cnt     <= '0;
                            state        <= WAIT_BUSY;
                        end else if (hold_cnt == HOLD_END) begin
                            bus.hold_timeout <= 1'b1;
                            bus.grant_valid  <= 1'b0;
                            bus.busy         <= 1'b0;
                            rr_ptr           <= bus.grant_id + 2'd1;
                            hold_cnt         <= '0;
                            state            <= IDLE;
                        end else begin
                            hold_cnt <= hold_cnt + 8'd1;
                        end
                    end
                end
                WAIT_BUSY: begin
                    if (!bus.tx_rdy) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (bus.tx_rdy) begin
                        if (last) begin
                            bus.grant_valid <= 1'b0;
                            bus.busy        <= 1'b0;
                            rr_ptr          <= bus.grant_id + 2'd1;
                            state           <= IDLE;
                        end else begin
                            state <= SEND;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small transmit-engine model.
// Single-byte arbitration vectors come from a table; corner cases are sequences.
module tb_uart_tx_arbiter;
    localparam int HOLD = 8;
    localparam logic [31:0] DATA = 32'h8372_4110;

    typedef struct packed {
        logic [3:0] req;
        logic [1:0] win;
        logic [7:0] dat;
    } vec_t;

    logic clk = 1'b0;
    logic rstsb;
    logic eng_hold;
    logic [2:0] eng_cnt;
    int checks = 0;
    int errors = 0;
    int got;
    int bad;
    int cnt;
    int bi;
    vec_t vecs [8];
    logic [3:0] acks [4];
    logic [7:0] datas [4];

    uart_tx_arbiter_if bus ();

    uart_tx_arbiter #(
        .NREQ(4),
        .HOLD_MAX(HOLD)
    ) dut (
        .clk(clk),
        .rstsb(rstsb),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Engine: goes busy the edge after a load strobe, idle again 3 edges later
    always @(posedge clk or negedge rstsb) begin
        if (!rstsb) eng_cnt <= 3'd0;
        else if (bus.tx_write) eng_cnt <= 3'd3;
        else if (eng_cnt != 3'd0) eng_cnt <= eng_cnt - 3'd1;
    end
    assign bus.tx_rdy = (eng_cnt == 3'd0) && !eng_hold;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (bus.busy && n < 60) begin
            tick();
            n++;
        end
        chk({nm, " idle"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic wait_write(input string nm);
        int n = 0;
        while (!bus.tx_write && n < 60) begin
            tick();
            n++;
        end
        chk({nm, " tx_write"}, 32'(bus.tx_write), 32'd1);
    endtask

    initial begin
        vecs[0] = '{4'b0010, 2'd1, 8'h41};
        vecs[1] = '{4'b1111, 2'd2, 8'h72};
        vecs[2] = '{4'b0011, 2'd0, 8'h10};
        vecs[3] = '{4'b1000, 2'd3, 8'h83};
        vecs[4] = '{4'b0101, 2'd0, 8'h10};
        vecs[5] = '{4'b0101, 2'd2, 8'h72};
        vecs[6] = '{4'b0110, 2'd1, 8'h41};
        vecs[7] = '{4'b1001, 2'd3, 8'h83};

        rstsb        = 1'b0;
        eng_hold     = 1'b0;
        bus.req      = '0;
        bus.req_data = DATA;
        bus.req_last = 4'hF;
        tick();
        tick();
        chk("reset outputs",
            32'({bus.ack, bus.tx_write, bus.tx_data, bus.grant_valid,
                 bus.grant_id, bus.busy, bus.hold_timeout}), 32'd0);
        rstsb = 1'b1;
        tick();

        for (int v = 0; v < 8; v++) begin
            bus.req = vecs[v].req;
            tick();
            chk($sformatf("v%0d grant_valid", v), 32'(bus.grant_valid), 32'd1);
            chk($sformatf("v%0d grant_id", v), 32'(bus.grant_id),
                32'(vecs[v].win));
            tick();
            chk($sformatf("v%0d tx_write", v), 32'(bus.tx_write), 32'd1);
            chk($sformatf("v%0d ack", v), 32'(bus.ack),
                32'(4'b0001 << vecs[v].win));
            chk($sformatf("v%0d tx_data", v), 32'(bus.tx_data),
                32'(vecs[v].dat));
            bus.req = '0;
            tick();
            chk($sformatf("v%0d pulse", v), 32'({bus.tx_write, bus.ack}),
                32'd0);
            wait_idle($sformatf("v%0d", v));
            chk($sformatf("v%0d release", v), 32'(bus.grant_valid), 32'd0);
        end

        // Two single-byte requesters held together alternate
        bus.req = 4'b0101;
        got = 0;
        for (int n = 0; n < 80 && got < 4; n++) begin
            tick();
            if (bus.tx_write) begin
                acks[got] = bus.ack;
                got++;
            end
        end
        bus.req = '0;
        chk("rr events", 32'(got), 32'd4);
        chk("rr ack0", 32'(acks[0]), 32'h1);
        chk("rr ack1", 32'(acks[1]), 32'h4);
        chk("rr ack2", 32'(acks[2]), 32'h1);
        chk("rr ack3", 32'(acks[3]), 32'h4);
        wait_idle("rr");

        // Locked 3-byte packet from 0 while 3 waits
        bi = 0;
        bus.req_last = 4'b1000;
        bus.req = 4'b0001;
        tick();
        chk("lock grant_id", 32'(bus.grant_id), 32'd0);
        bus.req[3] = 1'b1;
        got = 0;
        for (int n = 0; n < 150 && got < 4; n++) begin
            tick();
            if (bus.tx_write) begin
                acks[got]  = bus.ack;
                datas[got] = bus.tx_data;
                got++;
            end
            if (bus.ack[0]) begin
                bi++;
                if (bi == 3) begin
                    bus.req[0] = 1'b0;
                end else begin
                    bus.req_data[7:0] = 8'h10 + 8'(bi);
                    bus.req_last[0]   = (bi == 2);
                end
            end
            if (bus.ack[3]) bus.req[3] = 1'b0;
        end
        chk("lock events", 32'(got), 32'd4);
        chk("lock ack0", 32'(acks[0]), 32'h1);
        chk("lock ack1", 32'(acks[1]), 32'h1);
        chk("lock ack2", 32'(acks[2]), 32'h1);
        chk("lock ack3", 32'(acks[3]), 32'h8);
        chk("lock data", 32'({datas[0], datas[1], datas[2], datas[3]}),
            32'h1011_1283);
        wait_idle("lock");
        bus.req_data = DATA;

        // Owner 2 abandons its packet; stall timeout hands over to 3
        bus.req_last = 4'b0000;
        bus.req = 4'b0100;
        cnt = 0;
        while (!bus.ack[2] && cnt < 20) begin
            tick();
            cnt++;
        end
        chk("to ack2", 32'(bus.ack), 32'h4);
        bus.req = 4'b1000;
        bus.req_last = 4'b1000;
        cnt = 0;
        while (bus.tx_rdy && cnt < 20) begin
            tick();
            cnt++;
        end
        while (!bus.tx_rdy && cnt < 40) begin
            tick();
            cnt++;
        end
        cnt = 0;
        while (!bus.hold_timeout && cnt < 40) begin
            tick();
            cnt++;
        end
        chk("to cycles", 32'(cnt), 32'(HOLD + 1));
        chk("to pulse", 32'(bus.hold_timeout), 32'd1);
        chk("to released", 32'({bus.grant_valid, bus.busy}), 32'd0);
        tick();
        chk("to pulse end", 32'(bus.hold_timeout), 32'd0);
        chk("to regrant", 32'({bus.grant_valid, bus.grant_id}), 32'h7);
        tick();
        chk("to ack3", 32'({bus.tx_write, bus.ack}), 32'h18);
        bus.req = '0;
        wait_idle("to");

        // Engine busy when the request arrives
        eng_hold = 1'b1;
        bus.req_last = 4'hF;
        bus.req = 4'b0010;
        bad = 0;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (bus.tx_write || bus.ack != 4'd0) bad++;
        end
        chk("hold no early write", 32'(bad), 32'd0);
        chk("hold grant", 32'({bus.grant_valid, bus.grant_id}), 32'h5);
        eng_hold = 1'b0;
        tick();
        chk("hold write", 32'({bus.tx_write, bus.ack, bus.tx_data}),
            32'h1241);
        bus.req = '0;
        wait_idle("hold");

        // Reset while waiting for the engine to finish a byte
        bus.req = 4'b0001;
        wait_write("rst");
        bus.req = '0;
        cnt = 0;
        while (bus.tx_rdy && cnt < 20) begin
            tick();
            cnt++;
        end
        tick();
        chk("rst busy before", 32'(bus.busy), 32'd1);
        #2;
        rstsb = 1'b0;
        #1;
        chk("rst async outputs",
            32'({bus.ack, bus.tx_write, bus.tx_data, bus.grant_valid,
                 bus.grant_id, bus.busy, bus.hold_timeout}), 32'd0);
        tick();
        tick();
        rstsb = 1'b1;
        bad = 0;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (bus.tx_write || bus.busy) bad++;
        end
        chk("rst no stray", 32'(bad), 32'd0);
        bus.req = 4'b1010;
        tick();
        chk("rst rr grant", 32'({bus.grant_valid, bus.grant_id}), 32'h5);
        tick();
        chk("rst write1", 32'({bus.tx_write, bus.ack}), 32'h12);
        bus.req[1] = 1'b0;
        tick();
        wait_write("rst second");
        chk("rst write3", 32'({bus.ack, bus.tx_data}), 32'h883);
        bus.req = '0;
        wait_idle("rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
